logic_unit_multicycle: RTL and testbench

- Parametrised, multi-mode successor to the single-function 8-bit OR unit.
- Computes OR/AND/XOR/NOR of two WIDTH-bit operands, SLICE bits per clock, under a START/BUSY/DONE handshake.
- Sits beside the ALU for wide or low-area logic operations. Operands and mode are latched at START, so the register file may change them while the unit is busy.

---
 rtl/logic_unit_multicycle.sv | 108 ++++++++++
 tb/tb_logic_unit_multicycle.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_multicycle.sv
// ==== logic_unit_multicycle: OR/AND/XOR/NOR over WIDTH bits, SLICE bits per clock -- rev 1.0 ====
`default_nettype none

module logic_unit_multicycle #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] MODE_OR  = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_NOR = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [1:0]       mode_q;

    logic [WIDTH-1:0] full_op;
    logic [WIDTH-1:0] acc_next;
    int               idx;

    // Whole-word op is formed, but only the current slice is merged into the accumulator.
    always_comb begin
        full_op  = '0;
        acc_next = acc;
        idx      = int'(cnt) * SLICE;
        case (mode_q)
            MODE_OR:  full_op = opa | opb;
            MODE_AND: full_op = opa & opb;
            MODE_XOR: full_op = opa ^ opb;
            MODE_NOR: full_op = ~(opa | opb);
            default:  full_op = '0;
        endcase
        acc_next[idx +: SLICE] = full_op[idx +: SLICE];
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            mode_q <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= '0;
            ZERO   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        opa    <= DATA1;
                        opb    <= DATA2;
                        mode_q <= MODE;
                        cnt    <= '0;
                        acc    <= '0;
                        BUSY   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    DONE <= 1'b0;
                    acc  <= acc_next;
                    if (cnt == LAST) begin
                        // RESULT/ZERO only move here, so partial sums stay invisible.
                        RESULT <= acc_next;
                        ZERO   <= (acc_next == '0);
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_multicycle.sv
// ==== tb_logic_unit_multicycle: directed checks on 8/2, 16/16 and 32/4 instances -- rev 1.0 ====
`default_nettype none

module tb_logic_unit_multicycle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic        start_v [3] = '{1'b0, 1'b0, 1'b0};

    logic        busy_v [3];
    logic        done_v [3];
    logic        zero_v [3];
    logic [31:0] res_v  [3];

    logic [7:0]  res8;
    logic [15:0] res16;
    logic [31:0] res32;

    int          nv   [3] = '{4, 1, 8};
    logic [31:0] mask [3] = '{32'h0000_00FF, 32'h0000_FFFF, 32'hFFFF_FFFF};
    logic [31:0] prev [3] = '{32'h0, 32'h0, 32'h0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_unit_multicycle #(.WIDTH(8), .SLICE(2)) u_dut8 (
        .CLK(clk), .RESET(rst_n), .START(start_v[0]), .MODE(mode),
        .DATA1(d1[7:0]), .DATA2(d2[7:0]),
        .BUSY(busy_v[0]), .DONE(done_v[0]), .RESULT(res8), .ZERO(zero_v[0])
    );

    logic_unit_multicycle #(.WIDTH(16), .SLICE(16)) u_dut16 (
        .CLK(clk), .RESET(rst_n), .START(start_v[1]), .MODE(mode),
        .DATA1(d1[15:0]), .DATA2(d2[15:0]),
        .BUSY(busy_v[1]), .DONE(done_v[1]), .RESULT(res16), .ZERO(zero_v[1])
    );

    logic_unit_multicycle #(.WIDTH(32), .SLICE(4)) u_dut32 (
        .CLK(clk), .RESET(rst_n), .START(start_v[2]), .MODE(mode),
        .DATA1(d1), .DATA2(d2),
        .BUSY(busy_v[2]), .DONE(done_v[2]), .RESULT(res32), .ZERO(zero_v[2])
    );

    assign res_v[0] = {24'h0, res8};
    assign res_v[1] = {16'h0, res16};
    assign res_v[2] = res32;

    initial begin
        if ((8 % 2) != 0 || (16 % 16) != 0 || (32 % 4) != 0)
            $fatal(1, "WIDTH is not a multiple of SLICE");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        case (m)
            2'b00:   return a | b;
            2'b01:   return a & b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic run_op(input int s, input logic [1:0] m, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int cyc;
        exp = model(m, a, b) & mask[s];
        @(negedge clk);
        mode = m; d1 = a; d2 = b; start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, 32'(busy_v[s]), 32'd1);
        while (!done_v[s] && cyc < 64) begin
            check({tag, "_hold"}, res_v[s], prev[s]);
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(nv[s] + 1));
        check({tag, "_res"}, res_v[s], exp);
        check({tag, "_zero"}, 32'(zero_v[s]), 32'(exp == 32'h0));
        check({tag, "_busy_end"}, 32'(busy_v[s]), 32'd0);
        prev[s] = exp;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_v[s]), 32'd0);
    endtask

    initial begin
        int cnt;
        int gap;
        logic [31:0] seen;

        // Reset values
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", 32'(busy_v[i]), 32'd0);
            check("rst_done", 32'(done_v[i]), 32'd0);
            check("rst_res",  res_v[i], 32'h0);
            check("rst_zero", 32'(zero_v[i]), 32'd0);
        end
        rst_n = 1'b1;

        run_op(0, 2'b00, 32'hA5, 32'h0F, "or_a5_0f");
        run_op(0, 2'b01, 32'hF0, 32'h0F, "and_f0_0f");
        run_op(0, 2'b11, 32'h00, 32'h00, "nor_00_00");

        // Operand/mode changes and a stray START during RUN are ignored
        @(negedge clk);
        mode = 2'b10; d1 = 32'hFF; d2 = 32'h0F; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        d1 = 32'h00; mode = 2'b00; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("xor_chg_busy", 32'(busy_v[0]), 32'd1);
        cnt = 0;
        seen = 32'hDEAD_BEEF;
        for (int i = 0; i < 12; i++) begin
            if (done_v[0]) begin
                cnt++;
                seen = res_v[0];
            end
            @(negedge clk);
        end
        check("xor_chg_pulses", 32'(cnt), 32'd1);
        check("xor_chg_res", seen, 32'hF0);
        check("xor_chg_idle", 32'(busy_v[0]), 32'd0);
        prev[0] = 32'hF0;

        // Reset aborts an in-flight operation
        @(negedge clk);
        mode = 2'b10; d1 = 32'h3C; d2 = 32'hFF; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        check("abort_res", res_v[0], 32'h0);
        check("abort_zero", 32'(zero_v[0]), 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_v[0]) cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        check("abort_res_held", res_v[0], 32'h0);
        for (int i = 0; i < 3; i++) prev[i] = 32'h0;
        run_op(0, 2'b10, 32'h3C, 32'hFF, "xor_after_rst");

        // Back-to-back: second START during the first DONE cycle
        @(negedge clk);
        mode = 2'b01; d1 = 32'hFF; d2 = 32'h0F; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cnt = 1;
        while (!done_v[0] && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_first_lat", 32'(cnt), 32'd5);
        check("b2b_first_res", res_v[0], 32'h0F);
        check("b2b_gap_busy", 32'(busy_v[0]), 32'd0);
        mode = 2'b00; d1 = 32'h01; d2 = 32'h80; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("b2b_second_busy", 32'(busy_v[0]), 32'd1);
        check("b2b_done_low", 32'(done_v[0]), 32'd0);
        gap = 1;
        while (!done_v[0] && gap < 64) begin
            check("b2b_hold", res_v[0], 32'h0F);
            @(negedge clk);
            gap++;
        end
        check("b2b_done_spacing", 32'(gap), 32'd5);
        check("b2b_second_res", res_v[0], 32'h81);
        check("b2b_second_zero", 32'(zero_v[0]), 32'd0);
        prev[0] = 32'h81;
        @(negedge clk);
        check("b2b_done_end", 32'(done_v[0]), 32'd0);

        // Single-slice instance
        run_op(1, 2'b00, 32'h1234, 32'h4321, "w16_or");
        run_op(1, 2'b11, 32'hFFFF, 32'h0000, "w16_nor_zero");

        // 32-bit, 8 slices, against the bitwise model
        for (int m = 0; m < 4; m++)
            run_op(2, 2'(m), 32'hDEAD_BEEF, 32'h0F0F_1234, "w32_dir");
        run_op(2, 2'b00, 32'h0, 32'h0, "w32_or_zero");
        for (int i = 0; i < 3; i++)
            run_op(2, 2'($urandom_range(0, 3)), $urandom, $urandom, "w32_rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
